// File: rtl/writeback_stage_pkg.sv
// -----------------------------------------------------------------------------
// writeback_stage_pkg
// Shared MIPS definitions for the writeback stage: register index type, the
// hard-wired zero register, load-size encoding and the per-slot WB record.
// -----------------------------------------------------------------------------
package writeback_stage_pkg;

    localparam int XLEN = 32;

    // General-purpose register index.
    typedef logic [4:0] mips_reg_t;

    // $0 is hard-wired to zero; writes to it are dropped.
    localparam mips_reg_t ZERO = 5'd0;

    typedef enum logic [1:0] {
        LD_BYTE = 2'd0,
        LD_HALF = 2'd1,
        LD_WORD = 2'd2
    } ld_size_e;

    // One issue slot as held in the MEM/WB pipeline register.
    typedef struct packed {
        logic            valid;
        logic            wr;
        mips_reg_t       dest;
        logic [XLEN-1:0] result;
    } wb_slot_t;

endpackage : writeback_stage_pkg

// File: rtl/writeback_stage_load_aligner.sv
// -----------------------------------------------------------------------------
// load_aligner
// Combinational load-data alignment: picks the addressed little-endian byte or
// halfword lane out of a 32-bit read word and sign- or zero-extends it.
// Misaligned halfword/word accesses are not trapped; the result is simply the
// lane selected by the upper address bit (half) or the whole word (word).
//
// Ports:
//   i_rdata     in  32  raw data-memory word
//   i_size      in  2   access size (ld_size_e)
//   i_unsigned  in  1   zero-extend instead of sign-extend
//   i_addr_lo   in  2   low two address bits of the load
//   o_value     out 32  aligned, extended load value
// -----------------------------------------------------------------------------
module load_aligner
    import writeback_stage_pkg::*;
(
    input  logic [XLEN-1:0] i_rdata,
    input  ld_size_e        i_size,
    input  logic            i_unsigned,
    input  logic [1:0]      i_addr_lo,
    output logic [XLEN-1:0] o_value
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
    end

    // Halfword lane is chosen by addr bit 1 only; bit 0 is ignored.
    assign w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_value = i_rdata;
        case (i_size)
            LD_BYTE: o_value = {{24{~i_unsigned & w_byte[7]}}, w_byte};
            LD_HALF: o_value = {{16{~i_unsigned & w_half[15]}}, w_half};
            default: o_value = i_rdata;
        endcase
    end

endmodule : load_aligner

// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
// Final stage of the dual-issue pipeline. Holds the MEM/WB pipeline register,
// aligns load data for slot 0, drives both register-file write ports (slot 0 =
// older, slot 1 = younger) and exports the pending writes as forwarding sources.
//
// Optional feature (macro WB_PERF_EN): retired_count, a wrapping counter of
// valid WB slots that advance out of the stage.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   stall                         hold WB contents, suppress register writes
//   mem_flush                     capture the incoming MEM bundle as invalid
//   mem_pc                        PC of MEM slot 0
//   mem_valid/wr/dest/result{0,1} MEM slot contents
//   mem_is_load, mem_ld_size,
//   mem_ld_unsigned, mem_addr_lo  slot-0 load descriptor
//   dmem_rdata                    read data, valid only in a load's first WB cycle
//   wb_pc                         PC of WB slot 0
//   reg_write/write_addr/
//   write_data{0,1}               register-file write ports
//   fwd_valid/dest/data{0,1}      forwarding sources
//   retired_count                 retired slots (WB_PERF_EN only)
// -----------------------------------------------------------------------------
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                mem_flush,
    input  logic [XLEN-1:0]     mem_pc,
    input  logic                mem_valid0,
    input  logic                mem_valid1,
    input  logic                mem_wr0,
    input  logic                mem_wr1,
    input  logic [4:0]          mem_dest0,
    input  logic [4:0]          mem_dest1,
    input  logic [XLEN-1:0]     mem_result0,
    input  logic [XLEN-1:0]     mem_result1,
    input  logic                mem_is_load,
    input  logic [1:0]          mem_ld_size,
    input  logic                mem_ld_unsigned,
    input  logic [1:0]          mem_addr_lo,
    input  logic [XLEN-1:0]     dmem_rdata,
    output logic [XLEN-1:0]     wb_pc,
    output logic                reg_write0,
    output logic                reg_write1,
    output logic [4:0]          write_addr0,
    output logic [4:0]          write_addr1,
    output logic [XLEN-1:0]     write_data0,
    output logic [XLEN-1:0]     write_data1,
    output logic                fwd_valid0,
    output logic                fwd_valid1,
    output logic [4:0]          fwd_dest0,
    output logic [4:0]          fwd_dest1,
    output logic [XLEN-1:0]     fwd_data0,
    output logic [XLEN-1:0]     fwd_data1
`ifdef WB_PERF_EN
    ,
    output logic [RETIRE_W-1:0] retired_count
`endif
);

    // ---------------- MEM/WB pipeline register ----------------
    wb_slot_t        r_wb0;
    wb_slot_t        r_wb1;
    logic [XLEN-1:0] r_wb_pc;
    logic            r_is_load;
    ld_size_e        r_ld_size;
    logic            r_ld_unsigned;
    logic [1:0]      r_addr_lo;

    // Load hold: dmem_rdata is only good in the load's first WB cycle, so a
    // stalled load keeps its own copy.
    logic [XLEN-1:0] r_hold_data;
    logic            r_hold_flag;

    // NOTE: sequential state uses non-blocking assignments and an async reset,
    // so a reset during a stall drops the bundle without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb0         <= '0;
            r_wb1         <= '0;
            r_wb_pc       <= '0;
            r_is_load     <= 1'b0;
            r_ld_size     <= LD_BYTE;
            r_ld_unsigned <= 1'b0;
            r_addr_lo     <= 2'd0;
            r_hold_data   <= '0;
            r_hold_flag   <= 1'b0;
        end else if (!stall) begin
            r_wb0         <= '{valid: mem_valid0 & ~mem_flush, wr: mem_wr0,
                               dest: mem_dest0, result: mem_result0};
            r_wb1         <= '{valid: mem_valid1 & ~mem_flush, wr: mem_wr1,
                               dest: mem_dest1, result: mem_result1};
            r_wb_pc       <= mem_pc;
            r_is_load     <= mem_is_load;
            r_ld_size     <= ld_size_e'(mem_ld_size);
            r_ld_unsigned <= mem_ld_unsigned;
            r_addr_lo     <= mem_addr_lo;
            r_hold_flag   <= 1'b0;
        end else if (r_wb0.valid && r_is_load && !r_hold_flag) begin
            // First stalled cycle of a live load: freeze the read data.
            r_hold_data   <= dmem_rdata;
            r_hold_flag   <= 1'b1;
        end
    end

    // ---------------- Load alignment (slot 0) ----------------
    logic [XLEN-1:0] w_ld_rdata;
    logic [XLEN-1:0] w_ld_value;
    logic [XLEN-1:0] w_result0;

    assign w_ld_rdata = r_hold_flag ? r_hold_data : dmem_rdata;

    load_aligner u_load_aligner (
        .i_rdata    (w_ld_rdata),
        .i_size     (r_ld_size),
        .i_unsigned (r_ld_unsigned),
        .i_addr_lo  (r_addr_lo),
        .o_value    (w_ld_value)
    );

    assign w_result0 = r_is_load ? w_ld_value : r_wb0.result;

    // ---------------- Write qualification / WAW ----------------
    logic w_live0;
    logic w_live1;
    logic w_waw;

    assign w_live0 = r_wb0.valid & r_wb0.wr & (r_wb0.dest != ZERO);
    assign w_live1 = r_wb1.valid & r_wb1.wr & (r_wb1.dest != ZERO);
    // Same destination in one bundle: the younger slot's value is architectural.
    assign w_waw   = w_live0 & w_live1 & (r_wb0.dest == r_wb1.dest);

    assign fwd_valid0  = w_live0 & ~w_waw;
    assign fwd_valid1  = w_live1;
    assign fwd_dest0   = r_wb0.dest;
    assign fwd_dest1   = r_wb1.dest;
    assign fwd_data0   = w_result0;
    assign fwd_data1   = r_wb1.result;

    assign reg_write0  = fwd_valid0 & ~stall;
    assign reg_write1  = fwd_valid1 & ~stall;
    assign write_addr0 = r_wb0.dest;
    assign write_addr1 = r_wb1.dest;
    assign write_data0 = w_result0;
    assign write_data1 = r_wb1.result;

    assign wb_pc       = r_wb_pc;

`ifdef WB_PERF_EN
    // ---------------- Retired-slot counter ----------------
    // Counts every valid slot leaving WB, including wr=0 and WAW-suppressed ones.
    logic [RETIRE_W-1:0] r_retired_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retired_count <= '0;
        end else if (!stall) begin
            r_retired_count <= r_retired_count
                             + RETIRE_W'({1'b0, r_wb0.valid} + {1'b0, r_wb1.valid});
        end
    end

    assign retired_count = r_retired_count;
`endif

endmodule : writeback_stage

// File: tb/tb_writeback_stage.sv
// -----------------------------------------------------------------------------
// tb_writeback_stage
// Directed self-checking bench for writeback_stage. Inputs are driven 1 time
// unit after the rising edge; outputs are sampled 1 unit later.
// -----------------------------------------------------------------------------
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        mem_flush;
    logic [31:0] mem_pc;
    logic        mem_valid0, mem_valid1;
    logic        mem_wr0, mem_wr1;
    logic [4:0]  mem_dest0, mem_dest1;
    logic [31:0] mem_result0, mem_result1;
    logic        mem_is_load;
    logic [1:0]  mem_ld_size;
    logic        mem_ld_unsigned;
    logic [1:0]  mem_addr_lo;
    logic [31:0] dmem_rdata;
    logic [31:0] wb_pc;
    logic        reg_write0, reg_write1;
    logic [4:0]  write_addr0, write_addr1;
    logic [31:0] write_data0, write_data1;
    logic        fwd_valid0, fwd_valid1;
    logic [4:0]  fwd_dest0, fwd_dest1;
    logic [31:0] fwd_data0, fwd_data1;
`ifdef WB_PERF_EN
    logic [31:0] retired_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    writeback_stage #(.RETIRE_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .mem_flush       (mem_flush),
        .mem_pc          (mem_pc),
        .mem_valid0      (mem_valid0),
        .mem_valid1      (mem_valid1),
        .mem_wr0         (mem_wr0),
        .mem_wr1         (mem_wr1),
        .mem_dest0       (mem_dest0),
        .mem_dest1       (mem_dest1),
        .mem_result0     (mem_result0),
        .mem_result1     (mem_result1),
        .mem_is_load     (mem_is_load),
        .mem_ld_size     (mem_ld_size),
        .mem_ld_unsigned (mem_ld_unsigned),
        .mem_addr_lo     (mem_addr_lo),
        .dmem_rdata      (dmem_rdata),
        .wb_pc           (wb_pc),
        .reg_write0      (reg_write0),
        .reg_write1      (reg_write1),
        .write_addr0     (write_addr0),
        .write_addr1     (write_addr1),
        .write_data0     (write_data0),
        .write_data1     (write_data1),
        .fwd_valid0      (fwd_valid0),
        .fwd_valid1      (fwd_valid1),
        .fwd_dest0       (fwd_dest0),
        .fwd_dest1       (fwd_dest1),
        .fwd_data0       (fwd_data0),
        .fwd_data1       (fwd_data1)
`ifdef WB_PERF_EN
        ,
        .retired_count   (retired_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Advance to 1 unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        mem_flush       = 1'b0;
        mem_pc          = 32'h0;
        mem_valid0      = 1'b0;
        mem_valid1      = 1'b0;
        mem_wr0         = 1'b0;
        mem_wr1         = 1'b0;
        mem_dest0       = 5'd0;
        mem_dest1       = 5'd0;
        mem_result0     = 32'h0;
        mem_result1     = 32'h0;
        mem_is_load     = 1'b0;
        mem_ld_size     = 2'd0;
        mem_ld_unsigned = 1'b0;
        mem_addr_lo     = 2'd0;
    endtask

    task automatic drive_alu(input logic [31:0] pc,
                             input logic v0, input logic [4:0] d0, input logic [31:0] r0,
                             input logic v1, input logic [4:0] d1, input logic [31:0] r1);
        drive_idle();
        mem_pc      = pc;
        mem_valid0  = v0;
        mem_wr0     = 1'b1;
        mem_dest0   = d0;
        mem_result0 = r0;
        mem_valid1  = v1;
        mem_wr1     = 1'b1;
        mem_dest1   = d1;
        mem_result1 = r1;
    endtask

    task automatic drive_load(input logic [4:0] d0, input logic [1:0] size,
                              input logic uns, input logic [1:0] lo);
        drive_idle();
        mem_pc          = 32'h200;
        mem_valid0      = 1'b1;
        mem_wr0         = 1'b1;
        mem_dest0       = d0;
        mem_result0     = 32'h5555_5555;
        mem_is_load     = 1'b1;
        mem_ld_size     = size;
        mem_ld_unsigned = uns;
        mem_addr_lo     = lo;
    endtask

    // Capture one load, present rdata in its first WB cycle and check the value.
    task automatic load_case(input string tag, input logic [1:0] size, input logic uns,
                             input logic [1:0] lo, input logic [31:0] rdata,
                             input logic [31:0] expected);
        drive_load(5'd6, size, uns, lo);
        tick();
        drive_idle();
        dmem_rdata = rdata;
        #1;
        check({tag, "_we"}, 32'(reg_write0), 32'd1);
        check(tag, write_data0, expected);
    endtask

    initial begin
        rst        = 1'b1;
        stall      = 1'b0;
        dmem_rdata = 32'h0;
        drive_idle();

        // ---------------- Reset state ----------------
        #12;
        check("rst_wb_pc",   wb_pc, 32'h0);
        check("rst_we0",     32'(reg_write0), 32'd0);
        check("rst_we1",     32'(reg_write1), 32'd0);
        check("rst_fwd0",    32'(fwd_valid0), 32'd0);
        check("rst_fwd1",    32'(fwd_valid1), 32'd0);
        check("rst_addr0",   32'(write_addr0), 32'd0);
        check("rst_data1",   write_data1, 32'h0);
`ifdef WB_PERF_EN
        check("rst_retired", retired_count, 32'd0);
`endif
        rst = 1'b0;
        tick();

        // ---------------- 1: two independent writes ----------------
        drive_alu(32'h100, 1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22);
        tick();
        drive_idle();
        #1;
        check("t1_we0",   32'(reg_write0), 32'd1);
        check("t1_we1",   32'(reg_write1), 32'd1);
        check("t1_addr0", 32'(write_addr0), 32'd3);
        check("t1_addr1", 32'(write_addr1), 32'd4);
        check("t1_data0", write_data0, 32'h11);
        check("t1_data1", write_data1, 32'h22);
        check("t1_pc",    wb_pc, 32'h100);
        check("t1_fwd0",  32'(fwd_valid0), 32'd1);
        check("t1_fdat1", fwd_data1, 32'h22);

        // ---------------- 2: WAW inside one bundle ----------------
        drive_alu(32'h108, 1'b1, 5'd5, 32'hA, 1'b1, 5'd5, 32'hB);
        tick();
        drive_idle();
        #1;
        check("t2_we0",   32'(reg_write0), 32'd0);
        check("t2_fwd0",  32'(fwd_valid0), 32'd0);
        check("t2_we1",   32'(reg_write1), 32'd1);
        check("t2_data1", write_data1, 32'hB);
        check("t2_fwd1",  32'(fwd_valid1), 32'd1);

        // Idle bundle: nothing written.
        tick();
        check("idle_we0", 32'(reg_write0), 32'd0);
        check("idle_we1", 32'(reg_write1), 32'd0);

        // ---------------- 3: load alignment ----------------
        load_case("t3_lb3",  2'd0, 1'b0, 2'd3, 32'h80FF_FF00, 32'hFFFF_FF80);
        load_case("t3_lbu3", 2'd0, 1'b1, 2'd3, 32'h80FF_FF00, 32'h0000_0080);
        load_case("t3_lh2",  2'd1, 1'b0, 2'd2, 32'h80FF_FF00, 32'hFFFF_80FF);
        load_case("t3_lhu2", 2'd1, 1'b1, 2'd2, 32'h80FF_FF00, 32'h0000_80FF);
        load_case("t3_lb1",  2'd0, 1'b0, 2'd1, 32'h80FF_FF00, 32'hFFFF_FFFF);
        load_case("t3_lb0",  2'd0, 1'b0, 2'd0, 32'h80FF_FF00, 32'h0000_0000);
        load_case("t3_lh0",  2'd1, 1'b0, 2'd0, 32'h1234_7F01, 32'h0000_7F01);
        load_case("t3_lw",   2'd2, 1'b0, 2'd3, 32'h80FF_FF00, 32'h80FF_FF00);

        // ---------------- 4: stalled LW keeps its original data ----------------
        drive_load(5'd7, 2'd2, 1'b0, 2'd0);
        tick();
        drive_idle();
        dmem_rdata = 32'h1234_5678;
        stall      = 1'b1;
        #1;
        check("t4_we_s0",  32'(reg_write0), 32'd0);
        check("t4_fwd_s0", 32'(fwd_valid0), 32'd1);
        check("t4_fd_s0",  fwd_data0, 32'h1234_5678);
        for (int i = 1; i < 3; i++) begin
            tick();
            dmem_rdata = 32'h0000_DEAD;
            #1;
            check($sformatf("t4_we_s%0d", i),  32'(reg_write0), 32'd0);
            check($sformatf("t4_fwd_s%0d", i), 32'(fwd_valid0), 32'd1);
            check($sformatf("t4_fd_s%0d", i),  fwd_data0, 32'h1234_5678);
        end
        tick();
        dmem_rdata = 32'h0000_DEAD;
        stall      = 1'b0;
        #1;
        check("t4_we_rel",   32'(reg_write0), 32'd1);
        check("t4_addr_rel", 32'(write_addr0), 32'd7);
        check("t4_data_rel", write_data0, 32'h1234_5678);
        tick();
        check("t4_we_once",  32'(reg_write0), 32'd0);

        // ---------------- 5: $0, flush, reset during stall ----------------
        drive_alu(32'h300, 1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'h0);
        tick();
        drive_idle();
        #1;
        check("t5_zero_we",  32'(reg_write0), 32'd0);
        check("t5_zero_fwd", 32'(fwd_valid0), 32'd0);

        drive_alu(32'h308, 1'b1, 5'd8, 32'h66, 1'b1, 5'd9, 32'h77);
        mem_flush = 1'b1;
        tick();
        drive_idle();
        #1;
        check("t5_fl_we0",  32'(reg_write0), 32'd0);
        check("t5_fl_we1",  32'(reg_write1), 32'd0);
        check("t5_fl_fwd1", 32'(fwd_valid1), 32'd0);

        drive_alu(32'h310, 1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA);
        tick();
        drive_idle();
        stall = 1'b1;
        #1;
        check("t5_st_fwd0", 32'(fwd_valid0), 32'd1);
        check("t5_st_we0",  32'(reg_write0), 32'd0);
        #1;
        rst = 1'b1;
        #1;
        check("t5_rst_fwd0",  32'(fwd_valid0), 32'd0);
        check("t5_rst_fwd1",  32'(fwd_valid1), 32'd0);
        check("t5_rst_addr0", 32'(write_addr0), 32'd0);
        check("t5_rst_data1", write_data1, 32'h0);
        check("t5_rst_pc",    wb_pc, 32'h0);
        tick();
        rst   = 1'b0;
        stall = 1'b0;
        #1;
        check("t5_post_we0", 32'(reg_write0), 32'd0);
        check("t5_post_we1", 32'(reg_write1), 32'd0);
        tick();
        check("t5_post2_we0", 32'(reg_write0), 32'd0);

`ifdef WB_PERF_EN
        // ---------------- 6: retired counter ----------------
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
        check("t6_start", retired_count, 32'd0);
        for (int i = 0; i < 10; i++) begin
            drive_alu(32'h400 + 32'(8 * i), 1'b1, 5'(11 + i), 32'(i),
                      1'b1, 5'(11 + i), 32'(i + 100));
            tick();
            if (i == 3 || i == 6) begin
                drive_idle();
                stall = 1'b1;
                tick();
                stall = 1'b0;
            end
        end
        drive_idle();
        tick();
        check("t6_retired", retired_count, 32'd20);
        tick();
        check("t6_idle",    retired_count, 32'd20);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_writeback_stage
